// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front-end for the 5-stage MIPS-lite pipeline.
// After a `start` request in IDLE it pulses `valid` to the operation
// controller, then streams the instruction memory image sequentially from
// word 0, presenting each word to decode. Execute-stage branch redirects
// are followed. When a HALT word is delivered, or the last memory word has
// been read, the block drains for DRAIN_CYCLES cycles and pulses
// `opr_finished`.
//
// Parameters
//   AW            word-address width (memory depth 2**AW)
//   HALT_OP       opcode in bits [31:26] that marks HALT
//   DRAIN_CYCLES  cycles from HALT capture to the opr_finished pulse (>= 1)
//
// Ports
//   clk            in   rising-edge clock
//   rstb           in   asynchronous active-low reset
//   start          in   run request, sampled only in IDLE
//   fetch_en       in   fetch-stage enable from the controller
//   branch_taken   in   redirect request from execute
//   branch_target  in   redirect word address
//   mem_rd_en      out  memory read strobe (combinational)
//   mem_addr       out  memory word address (the pc)
//   mem_rdata      in   read data, valid the cycle after mem_rd_en
//   instr          out  registered instruction to decode
//   instr_valid    out  instr updated this cycle
//   instr_pc       out  word address of instr
//   valid          out  one-cycle start pulse to the controller
//   opr_finished   out  one-cycle completion pulse to the controller
//   busy           out  high in any state other than IDLE
//   eom_halt       out  sticky: end of memory reached without HALT
//   instr_count    out  instructions delivered since the last start
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int          AW           = 10,
  parameter logic [5:0]  HALT_OP      = 6'h11,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          fetch_en,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [AW-1:0] instr_pc,
  output logic          valid,
  output logic          opr_finished,
  output logic          busy,
  output logic          eom_halt,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int            CW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [AW-1:0] LAST_PC    = {AW{1'b1}};

  // True when a memory word carries the HALT opcode.
  function automatic logic is_halt(input logic [31:0] word);
    return (word[31:26] == HALT_OP);
  endfunction

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pend_addr;
  logic          pend;
  logic [CW-1:0] drain_cnt;
  logic [CW-1:0] drain_cnt_next;

  logic          rd_issue;
  logic          halt_seen;
  logic          branch_go;
  logic          track;
  logic          eom_hit;
  logic          run_start;
  logic          fin_next;

  // Cycle-level event decode: reads, halts, redirects and squashing.
  always_comb begin
    rd_issue  = (state == FETCH) && fetch_en;
    // Only data arriving while still fetching can stop the run; a HALT
    // word delivered during DRAIN (end-of-memory case) is just data.
    halt_seen = (state == FETCH) && pend && is_halt(mem_rdata);
    // HALT takes priority over a redirect arriving in the same cycle.
    branch_go = (state == FETCH) && branch_taken && !halt_seen;
    // A read issued under a redirect or a HALT is squashed: never tracked.
    track     = rd_issue && !branch_go && !halt_seen;
    eom_hit   = track && (pc == LAST_PC);
    run_start = (state == IDLE) && start;
  end

  assign mem_rd_en = rd_issue;
  assign mem_addr  = pc;

  // Next-state, next-pc and drain-counter logic.
  always_comb begin
    next_state     = state;
    pc_next        = pc;
    drain_cnt_next = drain_cnt;
    case (state)
      IDLE: begin
        if (run_start) begin
          next_state = FETCH;
          pc_next    = '0;
        end else begin
          next_state = IDLE;
        end
      end
      FETCH: begin
        if (halt_seen) begin
          next_state     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (branch_go) begin
          pc_next = branch_target;
        end else if (eom_hit) begin
          // Last word read: pc stays at the top address rather than wrap.
          next_state     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (rd_issue) begin
          pc_next = pc + AW'(1);
        end else begin
          pc_next = pc;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          next_state = IDLE;
        end else begin
          drain_cnt_next = drain_cnt - CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // Registered completion pulse lands in the DRAIN cycle whose count is 0.
    fin_next = (next_state == DRAIN) && (drain_cnt_next == '0);
  end

  // Control state: FSM, pc, outstanding-read tracking and drain counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      pc        <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      pend      <= track;
      drain_cnt <= drain_cnt_next;
      if (track) begin
        pend_addr <= pc;
      end
    end
  end

  // Registered outputs towards decode and the operation controller.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      instr        <= 32'h0000_0000;
      instr_valid  <= 1'b0;
      instr_pc     <= '0;
      valid        <= 1'b0;
      opr_finished <= 1'b0;
      busy         <= 1'b0;
      eom_halt     <= 1'b0;
      instr_count  <= 16'd0;
    end else begin
      valid        <= run_start;
      opr_finished <= fin_next;
      busy         <= (next_state != IDLE);
      instr_valid  <= pend;
      if (pend) begin
        instr    <= mem_rdata;
        instr_pc <= pend_addr;
      end
      if (run_start) begin
        instr_count <= 16'd0;
      end else if (pend) begin
        instr_count <= instr_count + 16'd1;
      end
      if (run_start) begin
        eom_halt <= 1'b0;
      end else if (eom_hit) begin
        eom_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed self-checking bench for instr_fetch. A behavioural 1024-word
// memory with one cycle of read latency sits on the memory port. Cycle c of
// a run is the cycle after the edge that sampled `start` (c = 1 is the first
// FETCH cycle); inputs are driven 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic          fetch_en;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;
  logic          valid;
  logic          opr_finished;
  logic          busy;
  logic          eom_halt;
  logic [15:0]   instr_count;

  logic [31:0]   mem [0:1023];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  localparam logic [31:0] HALT_WORD = 32'h4400_0000;

  instr_fetch #(.AW(AW), .HALT_OP(6'h11), .DRAIN_CYCLES(4)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .start         (start),
    .fetch_en      (fetch_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .valid         (valid),
    .opr_finished  (opr_finished),
    .busy          (busy),
    .eom_halt      (eom_halt),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [31:0] word_of(input int a);
    return 32'h0800_0000 | 32'(a);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  // Issue start in the current (IDLE) cycle; returns in the drive window of cycle 1.
  task automatic launch();
    next_cycle();
    start = 1'b1;
    mid();
    next_cycle();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk1({tag, "_iv"}, instr_valid, 1'b0);
    chk({tag, "_ipc"}, 32'(instr_pc), 32'h0);
    chk1({tag, "_valid"}, valid, 1'b0);
    chk1({tag, "_fin"}, opr_finished, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_eom"}, eom_halt, 1'b0);
    chk({tag, "_cnt"}, 32'(instr_count), 32'h0);
    chk1({tag, "_rden"}, mem_rd_en, 1'b0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
  endtask

  initial begin
    int deliv;
    int bad;
    int fin_cnt;
    int fin_cyc;
    int epc;
    logic eiv;

    rstb = 1'b0; start = 1'b0; fetch_en = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    clear_mem();

    // ---------------- reset state ----------------
    next_cycle(); next_cycle();
    mid();
    chk_all_zero("rst_held");
    next_cycle();
    rstb = 1'b1;
    mid();
    chk_all_zero("rst_rel");

    // ---------------- T1: basic run, HALT at word 4 ----------------
    clear_mem();
    for (int k = 0; k < 4; k++) mem[k] = word_of(k);
    mem[4] = HALT_WORD;
    launch();
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) next_cycle();
      mid();
      eiv = (c >= 3 && c <= 7);
      chk1($sformatf("t1_valid_c%0d", c), valid, c == 1);
      chk1($sformatf("t1_iv_c%0d", c), instr_valid, eiv);
      if (eiv) begin
        chk($sformatf("t1_ipc_c%0d", c), 32'(instr_pc), 32'(c - 3));
        chk($sformatf("t1_instr_c%0d", c), instr, mem[c - 3]);
      end
      chk1($sformatf("t1_fin_c%0d", c), opr_finished, c == 10);
      chk1($sformatf("t1_busy_c%0d", c), busy, c <= 10);
      if (c == 1) begin
        chk1("t1_rden_c1", mem_rd_en, 1'b1);
        chk("t1_addr_c1", 32'(mem_addr), 32'h0);
      end
      if (c == 2) chk("t1_rdata_c2", mem_rdata, mem[0]);
    end
    chk("t1_count", 32'(instr_count), 32'd5);
    chk1("t1_eom", eom_halt, 1'b0);

    // ---------------- T2: fetch_en low for cycles 4 and 5 ----------------
    clear_mem();
    for (int k = 0; k < 6; k++) mem[k] = word_of(k);
    mem[6] = HALT_WORD;
    launch();
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) next_cycle();
      fetch_en = !(c == 4 || c == 5);
      mid();
      eiv = (c >= 3 && c <= 5) || (c >= 8 && c <= 11);
      epc = (c <= 5) ? c - 3 : c - 5;
      chk1($sformatf("t2_iv_c%0d", c), instr_valid, eiv);
      if (eiv) chk($sformatf("t2_ipc_c%0d", c), 32'(instr_pc), 32'(epc));
      if (c >= 4 && c <= 6) chk($sformatf("t2_addr_c%0d", c), 32'(mem_addr), 32'd3);
      if (c == 4 || c == 5) chk1($sformatf("t2_rden_c%0d", c), mem_rd_en, 1'b0);
      chk1($sformatf("t2_fin_c%0d", c), opr_finished, c == 14);
      chk1($sformatf("t2_busy_c%0d", c), busy, c <= 14);
    end
    fetch_en = 1'b1;
    chk("t2_count", 32'(instr_count), 32'd7);

    // ---------------- T3: branch to 0x100 while reading address 3 ----------------
    clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = word_of(k);
    mem[10'h100] = word_of(32'h100);
    mem[10'h101] = word_of(32'h101);
    mem[10'h102] = HALT_WORD;
    launch();
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) next_cycle();
      branch_taken  = (c == 4);
      branch_target = 10'h100;
      mid();
      eiv = (c >= 3 && c <= 9 && c != 6);
      epc = (c <= 5) ? c - 3 : 32'h100 + c - 7;
      chk1($sformatf("t3_iv_c%0d", c), instr_valid, eiv);
      if (eiv) begin
        chk($sformatf("t3_ipc_c%0d", c), 32'(instr_pc), 32'(epc));
        chk($sformatf("t3_instr_c%0d", c), instr, mem[epc]);
      end
      if (c == 4) chk("t3_addr_c4", 32'(mem_addr), 32'd3);
      if (c == 5) chk("t3_addr_c5", 32'(mem_addr), 32'h100);
      chk1($sformatf("t3_fin_c%0d", c), opr_finished, c == 12);
    end
    branch_taken = 1'b0;
    chk("t3_count", 32'(instr_count), 32'd6);

    // ---------------- T4: no HALT, run to end of memory ----------------
    for (int k = 0; k < 1024; k++) mem[k] = word_of(k);
    launch();
    deliv = 0; bad = 0; fin_cnt = 0; fin_cyc = 0;
    for (int c = 1; c <= 1030; c++) begin
      if (c > 1) next_cycle();
      mid();
      if (instr_valid) begin
        if (deliv > 1023 || 32'(instr_pc) != 32'(deliv) || instr !== mem[deliv]) bad++;
        deliv++;
      end
      if (opr_finished) begin
        fin_cnt++;
        fin_cyc = c;
      end
      if (c == 1024) begin
        chk1("t4_rden_c1024", mem_rd_en, 1'b1);
        chk("t4_addr_c1024", 32'(mem_addr), 32'h3FF);
      end
      if (c == 1025) begin
        chk1("t4_rden_c1025", mem_rd_en, 1'b0);
        chk("t4_addr_c1025", 32'(mem_addr), 32'h3FF);
        chk1("t4_eom_c1025", eom_halt, 1'b1);
      end
    end
    chk("t4_seq_errors", 32'(bad), 32'd0);
    chk("t4_delivered", 32'(deliv), 32'd1024);
    chk("t4_count", 32'(instr_count), 32'd1024);
    chk1("t4_eom", eom_halt, 1'b1);
    chk("t4_fin_pulses", 32'(fin_cnt), 32'd1);
    chk("t4_fin_cycle", 32'(fin_cyc), 32'd1028);
    chk1("t4_busy_end", busy, 1'b0);

    // ---------------- T5: HALT arrives with branch_taken ----------------
    clear_mem();
    for (int k = 0; k < 3; k++) mem[k] = word_of(k);
    mem[3] = HALT_WORD;
    mem[10'h200] = word_of(32'h200);
    launch();
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) next_cycle();
      branch_taken  = (c == 5);
      branch_target = 10'h200;
      mid();
      if (c == 1) chk1("t5_eom_cleared", eom_halt, 1'b0);
      eiv = (c >= 3 && c <= 6);
      chk1($sformatf("t5_iv_c%0d", c), instr_valid, eiv);
      if (eiv) chk($sformatf("t5_ipc_c%0d", c), 32'(instr_pc), 32'(c - 3));
      if (c == 5) chk("t5_addr_c5", 32'(mem_addr), 32'd4);
      if (c >= 6 && c <= 9) chk1($sformatf("t5_rden_c%0d", c), mem_rd_en, 1'b0);
      chk1($sformatf("t5_fin_c%0d", c), opr_finished, c == 9);
    end
    branch_taken = 1'b0;
    chk("t5_count", 32'(instr_count), 32'd4);

    // ---------------- T6: start ignored while busy, reset in DRAIN ----------------
    launch();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      start = (c == 2 || c == 7);
      mid();
      chk1($sformatf("t6_valid_c%0d", c), valid, c == 1);
      chk1($sformatf("t6_busy_c%0d", c), busy, 1'b1);
    end
    start = 1'b0;
    chk("t6_count_c8", 32'(instr_count), 32'd4);
    #1 rstb = 1'b0;
    #1;
    chk_all_zero("t6_async_rst");
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      mid();
      chk1($sformatf("t6_rst_fin_%0d", c), opr_finished, 1'b0);
      chk1($sformatf("t6_rst_busy_%0d", c), busy, 1'b0);
    end
    next_cycle();
    rstb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      mid();
      chk1($sformatf("t6_post_fin_%0d", c), opr_finished, 1'b0);
      chk1($sformatf("t6_post_busy_%0d", c), busy, 1'b0);
      chk1($sformatf("t6_post_valid_%0d", c), valid, 1'b0);
      chk1($sformatf("t6_post_rden_%0d", c), mem_rd_en, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
